// File: rtl/lcd_text_ctrl_if.sv
// Bundles the user character-write port and the lcd_comm command port of lcd_text_ctrl.
// The controller uses the slave modport. The user logic or lcd_comm side uses master.
interface lcd_text_ctrl_if #(
  parameter int ROWS  = 2,
  parameter int ROW_W = 2,
  parameter int COL_W = 5
);
  logic             we;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic [7:0]       char;
  logic             clr;
  logic             update;
  logic             busy;
  logic [ROWS-1:0]  dirty;
  // lc_start is a one-cycle strobe. lc_data and lc_system are valid only in the strobe cycle.
  // A new strobe is issued only when lc_busy is low, and never in two consecutive cycles.
  logic             lc_start;
  logic [7:0]       lc_data;
  logic             lc_system;
  logic             lc_busy;
  logic [2:0]       state_dbg;

  modport master (
    output we, row, col, char, clr, update, lc_busy,
    input  busy, dirty, lc_start, lc_data, lc_system, state_dbg
  );

  modport slave (
    input  we, row, col, char, clr, update, lc_busy,
    output busy, dirty, lc_start, lc_data, lc_system, state_dbg
  );
endinterface

// File: rtl/lcd_text_ctrl.sv
// Character-LCD frame controller: shadow text buffer, HD44780 init sequence and
// dirty-row refresh driving an lcd_comm command port.
module lcd_text_ctrl #(
  parameter int         ROWS         = 2,
  parameter int         COLS         = 16,
  parameter int         ROW_W        = 2,
  parameter int         COL_W        = 5,
  parameter logic [1:0] CURSOR_MODE  = 2'b00,
  parameter bit         AUTO_REFRESH = 1'b0
) (
  input logic            CLK,
  input logic            RST,
  lcd_text_ctrl_if.slave bus
);
  localparam int CELLS = ROWS * COLS;
  localparam int AW    = (CELLS > 1) ? $clog2(CELLS) : 1;

  typedef enum logic [2:0] {
    S_INIT = 3'd0,
    S_IDLE = 3'd1,
    S_SCAN = 3'd2,
    S_ADDR = 3'd3,
    S_CHAR = 3'd4
  } state_t;

  state_t           state, state_n;
  logic [2:0]       init_idx, init_idx_n;
  logic [ROW_W-1:0] cur_row, cur_row_n;
  logic [COL_W-1:0] col_idx, col_idx_n;
  logic             holdoff;
  logic [ROWS-1:0]  dirty, dirty_n;
  logic [7:0]       mem [CELLS];

  logic             wr_ok;
  logic [AW-1:0]    wr_addr, rd_addr;
  logic             any_dirty;
  logic [ROW_W-1:0] first_dirty;
  logic             can_issue;
  logic             strobe;
  logic [7:0]       cmd_byte;
  logic             cmd_sys;
  logic             clear_row;

  function automatic logic [7:0] init_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    init_byte = (ROWS > 1) ? 8'h28 : 8'h20;
      3'd1:    init_byte = 8'h08;
      3'd2:    init_byte = 8'h01;
      3'd3:    init_byte = 8'h06;
      default: init_byte = {6'b000011, CURSOR_MODE};
    endcase
  endfunction

  // DDRAM line starts: rows 2/3 continue lines 0/1 after COLS characters.
  function automatic logic [7:0] row_base(input logic [ROW_W-1:0] r);
    int ri;
    ri = int'(r);
    row_base = (((ri & 1) != 0) ? 8'h40 : 8'h00) + (((ri & 2) != 0) ? 8'(COLS) : 8'h00);
  endfunction

  always_comb begin
    wr_ok   = (int'(bus.row) < ROWS) && (int'(bus.col) < COLS);
    wr_addr = AW'(int'(bus.row) * COLS + int'(bus.col));
    rd_addr = AW'(int'(cur_row) * COLS + int'(col_idx));
  end

  always_comb begin
    any_dirty   = 1'b0;
    first_dirty = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (dirty[r]) begin
        any_dirty   = 1'b1;
        first_dirty = ROW_W'(r);
      end
    end
  end

  // holdoff blocks the cycle right after a strobe so lcd_comm has time to raise lc_busy.
  assign can_issue = !bus.lc_busy && !holdoff;

  always_comb begin
    state_n    = state;
    init_idx_n = init_idx;
    cur_row_n  = cur_row;
    col_idx_n  = col_idx;
    strobe     = 1'b0;
    cmd_byte   = 8'h00;
    cmd_sys    = 1'b1;
    clear_row  = 1'b0;
    case (state)
      S_INIT: begin
        cmd_byte = init_byte(init_idx);
        if (can_issue) begin
          strobe = 1'b1;
          if (init_idx == 3'd4) state_n = S_IDLE;
          else init_idx_n = init_idx + 3'd1;
        end
      end
      S_IDLE: begin
        if (bus.update || (AUTO_REFRESH && any_dirty)) state_n = S_SCAN;
      end
      S_SCAN: begin
        if (any_dirty) begin
          cur_row_n = first_dirty;
          state_n   = S_ADDR;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_ADDR: begin
        cmd_byte = 8'h80 | row_base(cur_row);
        if (can_issue) begin
          strobe    = 1'b1;
          clear_row = 1'b1;
          col_idx_n = '0;
          state_n   = S_CHAR;
        end
      end
      S_CHAR: begin
        cmd_byte = mem[rd_addr];
        cmd_sys  = 1'b0;
        if (can_issue) begin
          strobe = 1'b1;
          if (col_idx == COL_W'(COLS - 1)) state_n = S_SCAN;
          else col_idx_n = col_idx + COL_W'(1);
        end
      end
      default: state_n = S_INIT;
    endcase
  end

  // A set from a write or a clear overrides the clear from the address strobe, so the row is sent again.
  always_comb begin
    dirty_n = dirty;
    for (int r = 0; r < ROWS; r++) begin
      if (clear_row && (int'(cur_row) == r)) dirty_n[r] = 1'b0;
    end
    if (bus.clr) begin
      dirty_n = '1;
    end else if (bus.we && wr_ok) begin
      for (int r = 0; r < ROWS; r++) begin
        if (int'(bus.row) == r) dirty_n[r] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state    <= S_INIT;
      init_idx <= 3'd0;
      cur_row  <= '0;
      col_idx  <= '0;
      holdoff  <= 1'b1;
      dirty    <= '0;
      for (int i = 0; i < CELLS; i++) mem[i] <= 8'h20;
    end else begin
      state    <= state_n;
      init_idx <= init_idx_n;
      cur_row  <= cur_row_n;
      col_idx  <= col_idx_n;
      holdoff  <= strobe;
      dirty    <= dirty_n;
      if (bus.clr) begin
        for (int i = 0; i < CELLS; i++) mem[i] <= 8'h20;
      end else if (bus.we && wr_ok) begin
        mem[wr_addr] <= bus.char;
      end
    end
  end

  assign bus.lc_start  = strobe;
  assign bus.lc_data   = strobe ? cmd_byte : 8'h00;
  assign bus.lc_system = strobe ? cmd_sys : 1'b1;
  assign bus.busy      = (state != S_IDLE);
  assign bus.dirty     = dirty;
  assign bus.state_dbg = state;
endmodule

// File: tb/tb_lcd_text_ctrl.sv
// Bench for lcd_text_ctrl: a 2x16 manual-refresh instance and a 4x20 auto-refresh instance,
// each served by a 20-cycle lcd_comm busy model, with command bytes checked against expected queues.
module tb_lcd_text_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  int   vectors     = 0;
  int   miscompares = 0;
  int   cnt_a       = 0;
  int   cnt_b       = 0;
  int   n_data_a    = 0;
  logic [8:0] exp_a[$];
  logic [8:0] exp_b[$];

  lcd_text_ctrl_if #(.ROWS(2), .ROW_W(2), .COL_W(5)) bus_a ();
  lcd_text_ctrl_if #(.ROWS(4), .ROW_W(2), .COL_W(5)) bus_b ();

  lcd_text_ctrl #(.ROWS(2), .COLS(16), .ROW_W(2), .COL_W(5),
                  .CURSOR_MODE(2'b00), .AUTO_REFRESH(1'b0))
    dut_a (.CLK(clk), .RST(rst_a), .bus(bus_a));

  lcd_text_ctrl #(.ROWS(4), .COLS(20), .ROW_W(2), .COL_W(5),
                  .CURSOR_MODE(2'b10), .AUTO_REFRESH(1'b1))
    dut_b (.CLK(clk), .RST(rst_b), .bus(bus_b));

  // lcd_comm stand-in: busy for 20 cycles after each accepted strobe
  always @(posedge clk) begin
    if (bus_a.lc_start) cnt_a <= 20;
    else if (cnt_a > 0) cnt_a <= cnt_a - 1;
    if (bus_b.lc_start) cnt_b <= 20;
    else if (cnt_b > 0) cnt_b <= cnt_b - 1;
  end
  assign bus_a.lc_busy = (cnt_a != 0);
  assign bus_b.lc_busy = (cnt_b != 0);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int which, input logic [8:0] v);
    if (which == 0) exp_a.push_back(v);
    else exp_b.push_back(v);
  endtask

  task automatic push_init(input int which, input logic [7:0] last);
    push(which, 9'h128); push(which, 9'h108); push(which, 9'h101);
    push(which, 9'h106); push(which, {1'b1, last});
  endtask

  task automatic push_row(input int which, input logic [7:0] addr, input int cols,
                          input int hot_col, input logic [7:0] hot_ch);
    push(which, {1'b1, addr});
    for (int c = 0; c < cols; c++) push(which, {1'b0, (c == hot_col) ? hot_ch : 8'h20});
  endtask

  // scoreboard: every strobe pops one expected {lc_system, lc_data}
  always @(negedge clk) begin
    if (bus_a.lc_start) begin
      if (!bus_a.lc_system) n_data_a++;
      check("a_busy_at_strobe", bus_a.lc_busy, 0);
      check("a_strobe_expected", exp_a.size() > 0, 1);
      if (exp_a.size() > 0) check("a_cmd", {bus_a.lc_system, bus_a.lc_data}, exp_a.pop_front());
    end
    if (bus_b.lc_start) begin
      check("b_busy_at_strobe", bus_b.lc_busy, 0);
      check("b_strobe_expected", exp_b.size() > 0, 1);
      if (exp_b.size() > 0) check("b_cmd", {bus_b.lc_system, bus_b.lc_data}, exp_b.pop_front());
    end
  end

  task automatic wr(input int which, input int r, input int c, input logic [7:0] ch);
    @(negedge clk);
    if (which == 0) begin
      bus_a.we = 1'b1; bus_a.row = 2'(r); bus_a.col = 5'(c); bus_a.char = ch;
    end else begin
      bus_b.we = 1'b1; bus_b.row = 2'(r); bus_b.col = 5'(c); bus_b.char = ch;
    end
    @(negedge clk);
    bus_a.we = 1'b0;
    bus_b.we = 1'b0;
  endtask

  task automatic pulse_update(input int which);
    @(negedge clk);
    if (which == 0) bus_a.update = 1'b1; else bus_b.update = 1'b1;
    @(negedge clk);
    bus_a.update = 1'b0;
    bus_b.update = 1'b0;
  endtask

  task automatic pulse_clr(input int which);
    @(negedge clk);
    if (which == 0) bus_a.clr = 1'b1; else bus_b.clr = 1'b1;
    @(negedge clk);
    bus_a.clr = 1'b0;
    bus_b.clr = 1'b0;
  endtask

  task automatic wait_idle(input int which, input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (((which == 0) ? (bus_a.busy || exp_a.size() != 0)
                             : (bus_b.busy || exp_b.size() != 0)) && n < 6000);
    check(tag, n < 6000, 1);
  endtask

  task automatic wait_strobe(input int which, input logic [7:0] data, input string tag);
    int n = 0;
    while (!((which == 0) ? (bus_a.lc_start && bus_a.lc_data == data)
                          : (bus_b.lc_start && bus_b.lc_data == data)) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(tag, n < 3000, 1);
  endtask

  task automatic reset_checks(input int which);
    if (which == 0) begin
      check("a_rst_lc_start", bus_a.lc_start, 0);
      check("a_rst_lc_data", bus_a.lc_data, 0);
      check("a_rst_lc_system", bus_a.lc_system, 1);
      check("a_rst_busy", bus_a.busy, 1);
      check("a_rst_dirty", bus_a.dirty, 0);
      check("a_rst_state", bus_a.state_dbg, 0);
    end else begin
      check("b_rst_lc_start", bus_b.lc_start, 0);
      check("b_rst_lc_data", bus_b.lc_data, 0);
      check("b_rst_lc_system", bus_b.lc_system, 1);
      check("b_rst_busy", bus_b.busy, 1);
      check("b_rst_dirty", bus_b.dirty, 0);
      check("b_rst_state", bus_b.state_dbg, 0);
    end
  endtask

  initial begin
    int data_before;
    rst_a = 1'b0; rst_b = 1'b0;
    bus_a.we = 1'b0; bus_a.row = '0; bus_a.col = '0; bus_a.char = '0;
    bus_a.clr = 1'b0; bus_a.update = 1'b0;
    bus_b.we = 1'b0; bus_b.row = '0; bus_b.col = '0; bus_b.char = '0;
    bus_b.clr = 1'b0; bus_b.update = 1'b0;

    // reset values and init sequences
    push_init(0, 8'h0C);
    push_init(1, 8'h0E);
    repeat (3) @(negedge clk);
    reset_checks(0);
    reset_checks(1);
    rst_a = 1'b1; rst_b = 1'b1;
    wait_idle(0, "a_init_done");
    wait_idle(1, "b_init_done");
    check("a_idle_after_init", bus_a.busy, 0);
    check("b_idle_after_init", bus_b.busy, 0);

    // 'A' at row 1 col 3, manual refresh of row 1 only
    wr(0, 1, 3, 8'h41);
    check("a_dirty_r1", bus_a.dirty, 2'b10);
    push_row(0, 8'hC0, 16, 3, 8'h41);
    pulse_update(0);
    wait_idle(0, "a_row1_refresh");
    check("a_dirty_after_r1", bus_a.dirty, 2'b00);

    // write to row 0 during its address strobe: row 0 goes out twice
    wr(0, 0, 0, 8'h42);
    push_row(0, 8'h80, 16, 0, 8'h43);
    push_row(0, 8'h80, 16, 0, 8'h43);
    pulse_update(0);
    wait_strobe(0, 8'h80, "a_addr_r0_seen");
    bus_a.we = 1'b1; bus_a.row = 2'd0; bus_a.col = 5'd0; bus_a.char = 8'h43;
    @(negedge clk);
    bus_a.we = 1'b0;
    wait_idle(0, "a_row0_twice");
    check("a_dirty_after_twice", bus_a.dirty, 2'b00);

    // out-of-range writes are ignored; update with nothing dirty sends no data
    wr(0, 0, 16, 8'h57);
    check("a_dirty_col16", bus_a.dirty, 2'b00);
    wr(0, 2, 0, 8'h57);
    check("a_dirty_row2", bus_a.dirty, 2'b00);
    data_before = n_data_a;
    pulse_update(0);
    check("a_busy_pulse", bus_a.busy, 1);
    wait_idle(0, "a_empty_refresh");
    check("a_no_data_strobes", n_data_a, data_before);

    // clear fills spaces in both rows; a second update mid-refresh is dropped
    pulse_clr(0);
    check("a_dirty_clr", bus_a.dirty, 2'b11);
    push_row(0, 8'h80, 16, -1, 8'h00);
    push_row(0, 8'hC0, 16, -1, 8'h00);
    pulse_update(0);
    repeat (50) @(negedge clk);
    pulse_update(0);
    wait_idle(0, "a_clr_refresh");
    check("a_dirty_after_clr", bus_a.dirty, 2'b00);

    // 4x20 auto-refresh: rows 2 and 3 in index order
    push_row(1, 8'h94, 20, 0, 8'h58);
    push_row(1, 8'hD4, 20, 19, 8'h59);
    wr(1, 2, 0, 8'h58);
    wr(1, 3, 19, 8'h59);
    wait_idle(1, "b_rows23_refresh");
    check("b_dirty_after_r23", bus_b.dirty, 4'h0);

    // clear in idle refreshes every row without an update pulse
    push_row(1, 8'h80, 20, -1, 8'h00);
    push_row(1, 8'hC0, 20, -1, 8'h00);
    push_row(1, 8'h94, 20, -1, 8'h00);
    push_row(1, 8'hD4, 20, -1, 8'h00);
    pulse_clr(1);
    check("b_dirty_clr", bus_b.dirty, 4'hF);
    wait_idle(1, "b_clr_refresh");
    check("b_dirty_after_clr", bus_b.dirty, 4'h0);

    // reset in the middle of row 3, then the buffer must read back as spaces
    push_row(1, 8'hD4, 20, 0, 8'h5A);
    wr(1, 3, 0, 8'h5A);
    wait_strobe(1, 8'hD4, "b_addr_r3_seen");
    repeat (30) @(negedge clk);
    @(posedge clk); #1;
    rst_b = 1'b0;
    @(posedge clk); #1;
    exp_b.delete();
    push_init(1, 8'h0E);
    @(negedge clk);
    reset_checks(1);
    @(negedge clk);
    rst_b = 1'b1;
    wait_idle(1, "b_reinit");
    check("b_dirty_after_reinit", bus_b.dirty, 4'h0);
    push_row(1, 8'hD4, 20, 1, 8'h52);
    wr(1, 3, 1, 8'h52);
    wait_idle(1, "b_row3_after_reset");
    check("b_dirty_end", bus_b.dirty, 4'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
